// File: rtl/multi_interval_timer.sv
// NUM_CH prescaled down-counter timers with timeout flags and IRQs behind a 16-bit Avalon-MM slave.
// Register writes take effect next cycle, readdata has 1-cycle latency; the slave never stalls.
module multi_interval_timer #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned PS_W       = 8,
    parameter logic [31:0] RST_PERIOD = 32'h1DCD64FF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);
    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;
    localparam logic [2:0] REG_PRESCALE = 3'd6;
    localparam logic [CNT_W-1:0] RST_CNT = RST_PERIOD[CNT_W-1:0];

    logic                     wr;
    logic [1:0]               ch_sel;
    logic [2:0]               reg_sel;
    logic [NUM_CH-1:0][15:0]  ch_rdata;
    logic [15:0]              readdata_d, readdata_q;

    assign wr      = chipselect & ~write_n;
    assign ch_sel  = address[4:3];
    assign reg_sel = address[2:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] count_q, count_d, period_q, period_d, snap_q, snap_d;
        logic [PS_W-1:0]  ps_q, ps_d, ps_cnt_q, ps_cnt_d;
        logic [7:0]       tocnt_q, tocnt_d;
        logic             run_q, run_d, to_q, to_d, ito_q, ito_d, cont_q, cont_d;
        logic             zero_q, zero_d, reload_q, reload_d;
        logic             ch_wr, start, stop, tick, cnt_zero, timeout_event;
        logic [31:0]      period_ext, snap_ext;
        logic [15:0]      rdata;

        assign ch_wr         = wr & (ch_sel == 2'(i));
        assign cnt_zero      = (count_q == '0);
        assign tick          = run_q & (ps_cnt_q == '0);
        // zero_q resets high so a counter sitting at zero never fires right after reset
        assign timeout_event = cnt_zero & ~zero_q;
        assign period_ext    = 32'(period_q);
        assign snap_ext      = 32'(snap_q);

        always_comb begin
            count_d  = count_q;
            period_d = period_q;
            snap_d   = snap_q;
            ps_d     = ps_q;
            ps_cnt_d = ps_cnt_q;
            tocnt_d  = tocnt_q;
            run_d    = run_q;
            to_d     = to_q;
            ito_d    = ito_q;
            cont_d   = cont_q;
            zero_d   = cnt_zero;
            reload_d = 1'b0;
            start    = 1'b0;
            stop     = 1'b0;
            if (ch_wr) begin
                case (reg_sel)
                    REG_STATUS:  to_d = 1'b0;
                    REG_CONTROL: begin
                        ito_d  = writedata[0];
                        cont_d = writedata[1];
                        start  = writedata[2];
                        stop   = writedata[3];
                    end
                    REG_PERIOD_L: begin
                        period_d[15:0] = writedata;
                        reload_d       = 1'b1;
                    end
                    REG_PERIOD_H: begin
                        period_d[CNT_W-1:16] = writedata[CNT_W-17:0];
                        reload_d             = 1'b1;
                    end
                    REG_SNAP_L, REG_SNAP_H: snap_d = count_q;
                    REG_PRESCALE:           ps_d = writedata[PS_W-1:0];
                    default:                tocnt_d = '0;
                endcase
            end
            // the event is applied after the register clears so it is never lost
            if (timeout_event) begin
                to_d = 1'b1;
                if (tocnt_d != 8'hFF) tocnt_d = tocnt_d + 8'd1;
            end
            if (reload_q) begin
                count_d = period_q;
                run_d   = 1'b0;
            end else if (tick) begin
                if (cnt_zero) begin
                    count_d = period_q;
                    if (!cont_q) run_d = 1'b0;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            if (stop)  run_d = 1'b0;
            if (start) run_d = 1'b1;
            if (start | reload_q | tick) ps_cnt_d = ps_q;
            else if (run_q)              ps_cnt_d = ps_cnt_q - PS_W'(1);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                count_q  <= RST_CNT;
                period_q <= RST_CNT;
                snap_q   <= '0;
                ps_q     <= '0;
                ps_cnt_q <= '0;
                tocnt_q  <= '0;
                run_q    <= 1'b0;
                to_q     <= 1'b0;
                ito_q    <= 1'b0;
                cont_q   <= 1'b0;
                zero_q   <= 1'b1;
                reload_q <= 1'b0;
            end else begin
                count_q  <= count_d;
                period_q <= period_d;
                snap_q   <= snap_d;
                ps_q     <= ps_d;
                ps_cnt_q <= ps_cnt_d;
                tocnt_q  <= tocnt_d;
                run_q    <= run_d;
                to_q     <= to_d;
                ito_q    <= ito_d;
                cont_q   <= cont_d;
                zero_q   <= zero_d;
                reload_q <= reload_d;
            end
        end

        always_comb begin
            rdata = '0;
            case (reg_sel)
                REG_STATUS:   rdata = {14'd0, run_q, to_q};
                REG_CONTROL:  rdata = {14'd0, cont_q, ito_q};
                REG_PERIOD_L: rdata = period_ext[15:0];
                REG_PERIOD_H: rdata = period_ext[31:16];
                REG_SNAP_L:   rdata = snap_ext[15:0];
                REG_SNAP_H:   rdata = snap_ext[31:16];
                REG_PRESCALE: rdata = 16'(ps_q);
                default:      rdata = {8'd0, tocnt_q};
            endcase
        end

        assign ch_rdata[i] = rdata;
        assign irq_vec[i]  = to_q & ito_q;
    end

    always_comb begin
        readdata_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 2'(i)) readdata_d = ch_rdata[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata_q <= '0;
        else          readdata_q <= readdata_d;
    end

    assign readdata = readdata_q;
    assign irq      = |irq_vec;
endmodule

// File: tb/tb_multi_interval_timer.sv
// Bench for multi_interval_timer: directed scenarios plus randomized runs against an arithmetic timer model.
module tb_multi_interval_timer;
    localparam logic [2:0] R_STATUS = 3'd0, R_CONTROL = 3'd1, R_PERIOD_L = 3'd2, R_PERIOD_H = 3'd3;
    localparam logic [2:0] R_SNAP_L = 3'd4, R_SNAP_H = 3'd5, R_PRESCALE = 3'd6, R_TOCNT = 3'd7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;
    logic [1:0]  irq_vec;
    logic [15:0] rd;
    int          total = 0;
    int          bad = 0;

    multi_interval_timer dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq), .irq_vec(irq_vec)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Every bus task starts at a falling edge and consumes exactly one clock.
    task automatic bus_write(input logic [1:0] ch, input logic [2:0] rg, input logic [15:0] d);
        address = {ch, rg}; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    // Returns the register value as it stood when the task was called.
    task automatic bus_read(input logic [1:0] ch, input logic [2:0] rg, output logic [15:0] d);
        address = {ch, rg};
        @(negedge clk);
        d = readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chan_setup(input logic [1:0] ch, input int per, input int ps, input logic [15:0] ctrl);
        bus_write(ch, R_CONTROL, 16'h0008);
        bus_write(ch, R_PERIOD_L, per[15:0]);
        bus_write(ch, R_PERIOD_H, per[31:16]);
        bus_write(ch, R_PRESCALE, ps[15:0]);
        idle(1);
        bus_write(ch, R_STATUS, 16'h0000);
        bus_write(ch, R_TOCNT, 16'h0000);
        bus_write(ch, R_CONTROL, ctrl);
    endtask

    // Counter value after j prescaled ticks, starting from c in continuous mode.
    function automatic int exp_count(int c, int per, int j);
        if (j <= c) return c - j;
        return per - ((j - c - 1) % (per + 1));
    endfunction

    // Number of arrivals at zero within the first j ticks, saturated like TOCNT.
    function automatic int exp_events(int c, int per, int j);
        int e;
        if (j < c) return 0;
        e = 1 + (j - c) / (per + 1);
        return (e > 255) ? 255 : e;
    endfunction

    task automatic test_reset();
        total++; if (readdata !== 16'h0) begin bad++; $display("FAIL reset_readdata: got %h expected 0000", readdata); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
        @(negedge clk); reset_n = 1'b1;
        bus_read(2'd0, R_STATUS, rd);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL reset_status: got %h expected 0000", rd); end
        bus_read(2'd0, R_PERIOD_L, rd);
        total++; if (rd !== 16'h64FF) begin bad++; $display("FAIL reset_period_l: got %h expected 64ff", rd); end
        bus_read(2'd0, R_PERIOD_H, rd);
        total++; if (rd !== 16'h1DCD) begin bad++; $display("FAIL reset_period_h: got %h expected 1dcd", rd); end
        bus_read(2'd1, R_CONTROL, rd);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL reset_control: got %h expected 0000", rd); end
        bus_read(2'd1, R_TOCNT, rd);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL reset_tocnt: got %h expected 0000", rd); end
        bus_write(2'd2, R_PERIOD_L, 16'h1234);
        bus_read(2'd2, R_PERIOD_L, rd);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL unmapped_read: got %h expected 0000", rd); end
        bus_read(2'd0, R_PERIOD_L, rd);
        total++; if (rd !== 16'h64FF) begin bad++; $display("FAIL unmapped_write_leak: got %h expected 64ff", rd); end
    endtask

    task automatic test_periodic();
        chan_setup(2'd0, 4, 0, 16'h0007);
        idle(4);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL periodic_irq_early: got %b expected 0", irq); end
        idle(1);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL periodic_irq_rise: got %b expected 1", irq); end
        total++; if (irq_vec !== 2'b01) begin bad++; $display("FAIL periodic_irq_vec: got %b expected 01", irq_vec); end
        idle(10);
        bus_read(2'd0, R_TOCNT, rd);
        total++; if (rd !== 16'd3) begin bad++; $display("FAIL periodic_tocnt: got %0d expected 3", rd); end
        bus_write(2'd0, R_STATUS, 16'h0000);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL periodic_irq_clear: got %b expected 0", irq); end
        idle(2);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL periodic_irq_gap: got %b expected 0", irq); end
        idle(1);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL periodic_irq_again: got %b expected 1", irq); end
    endtask

    task automatic test_status_race();
        chan_setup(2'd0, 4, 0, 16'h0007);
        idle(4);
        bus_write(2'd0, R_STATUS, 16'h0000);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL race_irq: got %b expected 1", irq); end
        bus_read(2'd0, R_STATUS, rd);
        total++; if (rd !== 16'h0003) begin bad++; $display("FAIL race_status: got %h expected 0003", rd); end
        idle(3);
        bus_write(2'd0, R_TOCNT, 16'h0000);
        bus_read(2'd0, R_TOCNT, rd);
        total++; if (rd !== 16'd1) begin bad++; $display("FAIL race_tocnt: got %0d expected 1", rd); end
    endtask

    task automatic test_saturation();
        chan_setup(2'd0, 1, 0, 16'h0006);
        idle(600);
        bus_read(2'd0, R_TOCNT, rd);
        total++; if (rd !== 16'd255) begin bad++; $display("FAIL tocnt_saturate: got %0d expected 255", rd); end
        bus_write(2'd0, R_CONTROL, 16'h0008);
    endtask

    task automatic test_oneshot();
        chan_setup(2'd1, 2, 3, 16'h0005);
        idle(8);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_irq_early: got %b expected 0", irq); end
        idle(1);
        total++; if (irq_vec !== 2'b10) begin bad++; $display("FAIL oneshot_irq_vec: got %b expected 10", irq_vec); end
        bus_read(2'd1, R_STATUS, rd);
        total++; if (rd !== 16'h0003) begin bad++; $display("FAIL oneshot_running: got %h expected 0003", rd); end
        idle(3);
        bus_read(2'd1, R_STATUS, rd);
        total++; if (rd !== 16'h0001) begin bad++; $display("FAIL oneshot_stopped: got %h expected 0001", rd); end
        bus_write(2'd1, R_SNAP_L, 16'h0000);
        bus_read(2'd1, R_SNAP_L, rd);
        total++; if (rd !== 16'd2) begin bad++; $display("FAIL oneshot_reloaded: got %0d expected 2", rd); end
        idle(20);
        bus_read(2'd1, R_TOCNT, rd);
        total++; if (rd !== 16'd1) begin bad++; $display("FAIL oneshot_tocnt: got %0d expected 1", rd); end
    endtask

    task automatic test_period_zero();
        chan_setup(2'd1, 5, 0, 16'h0000);
        bus_write(2'd1, R_PERIOD_L, 16'h0000);
        idle(1);
        bus_write(2'd1, R_CONTROL, 16'h0006);
        idle(20);
        bus_read(2'd1, R_TOCNT, rd);
        total++; if (rd !== 16'd1) begin bad++; $display("FAIL period0_tocnt: got %0d expected 1", rd); end
        bus_read(2'd1, R_STATUS, rd);
        total++; if (rd !== 16'h0003) begin bad++; $display("FAIL period0_status: got %h expected 0003", rd); end
    endtask

    task automatic test_snapshot();
        chan_setup(2'd0, 1000, 0, 16'h0006);
        idle(100);
        bus_write(2'd0, R_SNAP_L, 16'h0000);
        bus_read(2'd0, R_SNAP_L, rd);
        total++; if (rd !== 16'd900) begin bad++; $display("FAIL snap_l: got %0d expected 900", rd); end
        bus_read(2'd0, R_SNAP_H, rd);
        total++; if (rd !== 16'd0) begin bad++; $display("FAIL snap_h: got %0d expected 0", rd); end
        bus_write(2'd0, R_PERIOD_L, 16'd50);
        idle(1);
        bus_read(2'd0, R_STATUS, rd);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL reload_stops: got %h expected 0000", rd); end
        bus_write(2'd0, R_SNAP_H, 16'h0000);
        idle(5);
        bus_read(2'd0, R_SNAP_L, rd);
        total++; if (rd !== 16'd50) begin bad++; $display("FAIL reload_count: got %0d expected 50", rd); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [1:0] ch;
            int per, ps, n, e_snap, e_tocnt, e_to;
            ch  = 2'($urandom_range(1, 0));
            per = int'($urandom_range(40, 1));
            ps  = int'($urandom_range(3, 0));
            n   = int'($urandom_range(150, 5));
            e_snap  = exp_count(per, per, n / (ps + 1));
            e_tocnt = exp_events(per, per, (n + 2) / (ps + 1));
            e_to    = (exp_events(per, per, (n + 3) / (ps + 1)) > 0) ? 1 : 0;
            chan_setup(ch, per, ps, 16'h0006);
            idle(n);
            bus_write(ch, R_SNAP_L, 16'h0000);
            bus_read(ch, R_SNAP_L, rd);
            total++; if (rd !== 16'(e_snap)) begin bad++; $display("FAIL rand_snap_l it%0d: got %0d expected %0d (per=%0d ps=%0d n=%0d)", it, rd, e_snap, per, ps, n); end
            bus_read(ch, R_SNAP_H, rd);
            total++; if (rd !== 16'd0) begin bad++; $display("FAIL rand_snap_h it%0d: got %0d expected 0", it, rd); end
            bus_read(ch, R_TOCNT, rd);
            total++; if (rd !== 16'(e_tocnt)) begin bad++; $display("FAIL rand_tocnt it%0d: got %0d expected %0d (per=%0d ps=%0d n=%0d)", it, rd, e_tocnt, per, ps, n); end
            bus_read(ch, R_STATUS, rd);
            total++; if (rd !== 16'(2 + e_to)) begin bad++; $display("FAIL rand_status it%0d: got %h expected %0h", it, rd, 2 + e_to); end
            bus_write(ch, R_CONTROL, 16'h0008);
        end
    endtask

    task automatic test_reset_mid();
        chan_setup(2'd0, 4, 0, 16'h0007);
        idle(6);
        bus_read(2'd0, R_PERIOD_L, rd);
        total++; if (rd !== 16'd4) begin bad++; $display("FAIL mid_period: got %0d expected 4", rd); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL mid_irq_before: got %b expected 1", irq); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq_async: got %b expected 0", irq); end
        total++; if (irq_vec !== 2'b00) begin bad++; $display("FAIL mid_irq_vec_async: got %b expected 00", irq_vec); end
        total++; if (readdata !== 16'h0) begin bad++; $display("FAIL mid_readdata_async: got %h expected 0000", readdata); end
        @(negedge clk); reset_n = 1'b1;
        bus_read(2'd0, R_STATUS, rd);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL mid_status: got %h expected 0000", rd); end
        bus_read(2'd0, R_TOCNT, rd);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL mid_tocnt: got %h expected 0000", rd); end
        bus_write(2'd0, R_SNAP_L, 16'h0000);
        bus_read(2'd0, R_SNAP_L, rd);
        total++; if (rd !== 16'h64FF) begin bad++; $display("FAIL mid_count_l: got %h expected 64ff", rd); end
        bus_read(2'd0, R_SNAP_H, rd);
        total++; if (rd !== 16'h1DCD) begin bad++; $display("FAIL mid_count_h: got %h expected 1dcd", rd); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_periodic();
        test_status_race();
        test_saturation();
        test_oneshot();
        test_period_zero();
        test_snapshot();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
